axi_sft_crossbar_rresp: RTL and testbench
=========================================

// Module: axi_sft_crossbar_rresp
// PURPOSE
//  Read-response return path for one crossbar slave interface S. It is the return end of the address decoder.
//  - Arbitrates R bursts from M_COUNT master interfaces back to the slave port.
//  - Synthesises DECERR bursts when the decoder flags an unmapped read.
//  - Returns a completion (s_cpl_id/s_cpl_valid) to the decoder's thread tracker.
// PARAMETERS
//  S           0      slave interface index; selects this port's column of M_CONNECT
//  S_COUNT     4      number of slave interfaces
//  M_COUNT     4      number of master interfaces
//  DATA_WIDTH  32     R data width
//  ID_WIDTH    8      ID width
//  M_CONNECT   all 1  M_COUNT fields of S_COUNT bits; masters not connected to S are never granted
// PORTS
//  clk             in   1                clock
//  rst_n           in   1                asynchronous active-low reset
//  rc_valid        in   1                decoder read command valid (decerr path only)
//  rc_decerr       in   1                command is a decode error; commands with rc_decerr=0 are acked and dropped
//  rc_id           in   ID_WIDTH         ARID of the failed read
//  rc_len          in   8                ARLEN of the failed read
//  rc_ready        out  1                command accepted
//  m_axi_rid       in   M_COUNT*ID_WIDTH per-master RID
//  m_axi_rdata     in   M_COUNT*DATA_WIDTH per-master RDATA
//  m_axi_rresp     in   M_COUNT*2        per-master RRESP
//  m_axi_rlast     in   M_COUNT          per-master RLAST
//  m_axi_rvalid    in   M_COUNT          per-master RVALID
//  m_axi_rready    out  M_COUNT          per-master RREADY; one-hot or zero
//  s_axi_rid/rdata/rresp/rlast/rvalid  out  ID_WIDTH/DATA_WIDTH/2/1/1  slave-port R channel
//  s_axi_rready    in   1                slave-port RREADY
//  s_cpl_id        out  ID_WIDTH         ID of the completed burst
//  s_cpl_valid     out  1                one-cycle completion pulse
//  tmr_mismatch    out  1                one-cycle pulse when any voted bit disagreed
// BEHAVIOUR
//  Reset values:
//  - State IDLE; grant and rr_ptr = 0; beat counter = 0.
//  - All outputs 0, including every m_axi_rready.
//  - Reset asserted mid-burst aborts immediately; no completion is produced.
//  FSM states: IDLE, FWD, DERR.
//  IDLE:
//  - If rc_valid: pulse rc_ready for one cycle.
//    - If rc_decerr: latch rc_id and rc_len, go DERR.
//    - If not rc_decerr: stay in IDLE.
//  - Else if any connected m_axi_rvalid is high: round-robin pick from rr_ptr upward (wrap at M_COUNT), register grant, go FWD.
//  - rc_valid wins when it coincides with rvalid.
//  - Arbitration costs 1 cycle; the first beat is forwarded the cycle after the pick.
//  FWD:
//  - Combinational pass-through of the granted master's R fields to s_axi_r*.
//  - m_axi_rready[grant] = s_axi_rready; all other rready bits are 0.
//  - Grant is locked until an rvalid&rready&rlast handshake, then go IDLE.
//  - rr_ptr <= grant+1 mod M_COUNT on that handshake.
//  DERR:
//  - Emit rc_len+1 beats: rid = latched id, rdata = 0, rresp = 2'b11; rlast on the final beat.
//  - The beat counter advances only on s_axi_rvalid&&s_axi_rready.
//  - rc_len=0 gives a single beat. rc_len=255 gives 256 beats; the 8-bit counter must not wrap early.
//  Completion:
//  - s_cpl_valid pulses the cycle after any last-beat handshake, FWD or DERR.
//  - s_cpl_id = rid of that beat.
//  Backpressure: s_axi_rready low holds all outputs stable; valid is never withdrawn.
//  No combinational path from s_axi_rready to s_axi_rvalid.
// CONFIGURATION
//  Macro AXI_SFT_RRESP_TMR_EN.
//  Defined:
//  - state, grant, rr_ptr and the beat counter are triplicated.
//  - Each copy reloads every cycle from the bitwise majority vote of all three (scrubbing).
//  - Outputs are driven from the voted value.
//  - tmr_mismatch pulses on any disagreement.
//  Undefined: single copy of each register; tmr_mismatch tied 0.
//  Cycle behaviour is identical in both builds.
// STRUCTURE
//  Shared package axi_sft_pkg: RRESP codes (OKAY=2'b00, DECERR=2'b11), rresp_state_t enum, clog2-based width constants.
//  Sub-module axi_tmr_simple_voter (parameterised width, d0/d1/d2 -> q), instantiated only under AXI_SFT_RRESP_TMR_EN.
//  Round-robin picker is a function inside this module.
// TESTING
//  1 Master 2 returns 4 beats, id 0x05, s_axi_rready held 1 -> 4 beats on the slave port, first one cycle after the pick; s_cpl_id=0x05 pulse one cycle after rlast; rr_ptr=3.
//  2 Masters 0,1,3 rvalid continuously with 2-beat bursts from rr_ptr=0 -> grant order 0,1,3,0; no interleaving within a burst.
//  3 rc_valid, rc_decerr=1, id 0x7, len 2 together with rvalid on master 0 -> DERR first: 3 beats rresp=3, rdata=0, last on beat 3; then master 0 is forwarded.
//  4 s_axi_rready toggling 1-0-1 during DERR with len 255 -> exactly 256 beats; outputs stable while stalled; single completion.
//  5 rst_n pulled low mid-burst in FWD -> all outputs 0 immediately; after release, IDLE with rr_ptr=0 and no s_cpl_valid.
//  6 TMR build: force one copy's grant to a wrong value for one cycle -> output grant unchanged, tmr_mismatch=1 for one cycle, copy scrubbed next cycle.

Source files
------------

// File: rtl/axi_sft_pkg.sv
// rtl/axi_sft_pkg.sv - shared types and constants for the AXI crossbar read-response path
// Purpose: RRESP codes, the read-response FSM state enum and width helpers.
// Ports: none (package).
package axi_sft_pkg;

  localparam logic [1:0] RRESP_OKAY   = 2'b00;
  localparam logic [1:0] RRESP_DECERR = 2'b11;

  // Beat counter covers ARLEN 0..255 without wrapping before the last beat.
  localparam int BEAT_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_DERR = 2'd2
  } rresp_state_t;

  localparam int STATE_W = $bits(rresp_state_t);

  // Index width for n items; never below one bit.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi_tmr_simple_voter.sv
// rtl/axi_tmr_simple_voter.sv - bitwise 2-of-3 majority voter
// Purpose: votes three redundant register copies into one value.
// Ports:
//   d0, d1, d2  in   WIDTH  redundant copies
//   q           out  WIDTH  bitwise majority
module axi_tmr_simple_voter #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  output logic [WIDTH-1:0] q
);

  assign q = (d0 & d1) | (d1 & d2) | (d0 & d2);

endmodule

// File: rtl/axi_sft_crossbar_rresp.sv
// rtl/axi_sft_crossbar_rresp.sv - crossbar slave-port read-response return path
// Purpose: round-robin arbitration of R bursts from the master interfaces back to
//   slave port S, DECERR burst generation for unmapped reads, and a completion
//   pulse to the decoder's thread tracker.
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   rc_valid/rc_decerr/rc_id/rc_len     decoder read command (decerr path)
//   rc_ready                            command accepted
//   m_axi_rid/rdata/rresp/rlast/rvalid  per-master R channels (flattened)
//   m_axi_rready                        per-master RREADY, one-hot or zero
//   s_axi_rid/rdata/rresp/rlast/rvalid  slave-port R channel
//   s_axi_rready                        slave-port RREADY
//   s_cpl_id, s_cpl_valid               completion of a finished burst
//   tmr_mismatch                        pulse when redundant copies disagree
// Configuration: define AXI_SFT_RRESP_TMR_EN to triplicate state, grant, rr_ptr
//   and the beat counter with majority-vote scrubbing.
module axi_sft_crossbar_rresp
  import axi_sft_pkg::*;
#(
  parameter int S          = 0,
  parameter int S_COUNT    = 4,
  parameter int M_COUNT    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 8,
  parameter logic [M_COUNT*S_COUNT-1:0] M_CONNECT = {M_COUNT*S_COUNT{1'b1}}
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       rc_valid,
  input  logic                       rc_decerr,
  input  logic [ID_WIDTH-1:0]        rc_id,
  input  logic [7:0]                 rc_len,
  output logic                       rc_ready,
  input  logic [M_COUNT*ID_WIDTH-1:0]   m_axi_rid,
  input  logic [M_COUNT*DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [M_COUNT*2-1:0]          m_axi_rresp,
  input  logic [M_COUNT-1:0]            m_axi_rlast,
  input  logic [M_COUNT-1:0]            m_axi_rvalid,
  output logic [M_COUNT-1:0]            m_axi_rready,
  output logic [ID_WIDTH-1:0]        s_axi_rid,
  output logic [DATA_WIDTH-1:0]      s_axi_rdata,
  output logic [1:0]                 s_axi_rresp,
  output logic                       s_axi_rlast,
  output logic                       s_axi_rvalid,
  input  logic                       s_axi_rready,
  output logic [ID_WIDTH-1:0]        s_cpl_id,
  output logic                       s_cpl_valid,
  output logic                       tmr_mismatch
);

  localparam int GW = sel_width(M_COUNT);
  localparam int VW = STATE_W + 2 * GW + BEAT_CNT_W;

  rresp_state_t          state_q, state_d;
  logic [GW-1:0]         grant_q, grant_d;
  logic [GW-1:0]         rr_q, rr_d;
  logic [BEAT_CNT_W-1:0] cnt_q, cnt_d;

  // All protected state travels as one vector so both builds share the FSM code.
  logic [VW-1:0] vec_d, vec_q;

  assign vec_d   = {state_d, grant_d, rr_d, cnt_d};
  assign state_q = rresp_state_t'(vec_q[VW-1 -: STATE_W]);
  assign grant_q = vec_q[2*GW+BEAT_CNT_W-1 -: GW];
  assign rr_q    = vec_q[GW+BEAT_CNT_W-1 -: GW];
  assign cnt_q   = vec_q[BEAT_CNT_W-1:0];

  logic [ID_WIDTH-1:0] derr_id_q;
  logic [7:0]          derr_len_q;
  logic [M_COUNT-1:0]  conn, req;
  logic                last_hs;

  // First requester at or above ptr, wrapping at M_COUNT.
  function automatic logic [GW-1:0] rr_pick(input logic [M_COUNT-1:0] r,
                                            input logic [GW-1:0] ptr);
    logic [GW-1:0] sel;
    logic          found;
    int            idx;
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < M_COUNT; i++) begin
      idx = (int'(ptr) + i) % M_COUNT;
      if (!found && r[idx]) begin
        sel   = GW'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  always_comb begin
    conn = '0;
    for (int m = 0; m < M_COUNT; m++) begin
      conn[m] = M_CONNECT[m*S_COUNT+S];
    end
  end

  assign req     = m_axi_rvalid & conn;
  assign last_hs = s_axi_rvalid & s_axi_rready & s_axi_rlast;

  // State register
`ifdef AXI_SFT_RRESP_TMR_EN
  logic [VW-1:0] tmr_q0, tmr_q1, tmr_q2;

  // Every copy reloads from next-state logic fed by the voted value, so a
  // single upset copy is overwritten on the following edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr_q0 <= '0;
      tmr_q1 <= '0;
      tmr_q2 <= '0;
    end else begin
      tmr_q0 <= vec_d;
      tmr_q1 <= vec_d;
      tmr_q2 <= vec_d;
    end
  end

  axi_tmr_simple_voter #(
    .WIDTH(VW)
  ) u_voter (
    .d0(tmr_q0),
    .d1(tmr_q1),
    .d2(tmr_q2),
    .q (vec_q)
  );

  assign tmr_mismatch = |((tmr_q0 ^ tmr_q1) | (tmr_q1 ^ tmr_q2));
`else
  logic [VW-1:0] reg_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_q <= '0;
    end else begin
      reg_q <= vec_d;
    end
  end

  assign vec_q        = reg_q;
  assign tmr_mismatch = 1'b0;
`endif

  // Next-state logic
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        // A pending decoder command takes priority over R arbitration.
        if (rc_valid) begin
          if (rc_decerr) begin
            state_d = ST_DERR;
            cnt_d   = '0;
          end
        end else if (|req) begin
          grant_d = rr_pick(req, rr_q);
          state_d = ST_FWD;
        end
      end
      ST_FWD: begin
        if (last_hs) begin
          state_d = ST_IDLE;
          rr_d    = (int'(grant_q) == M_COUNT - 1) ? '0 : grant_q + GW'(1);
        end
      end
      ST_DERR: begin
        if (s_axi_rvalid && s_axi_rready) begin
          if (cnt_q == derr_len_q) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + BEAT_CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output logic: depends on registered state only, so s_axi_rvalid never
  // sees s_axi_rready combinationally.
  always_comb begin
    rc_ready     = 1'b0;
    m_axi_rready = '0;
    s_axi_rid    = '0;
    s_axi_rdata  = '0;
    s_axi_rresp  = RRESP_OKAY;
    s_axi_rlast  = 1'b0;
    s_axi_rvalid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        rc_ready = rc_valid;
      end
      ST_FWD: begin
        for (int m = 0; m < M_COUNT; m++) begin
          if (grant_q == GW'(m)) begin
            s_axi_rid       = m_axi_rid[m*ID_WIDTH +: ID_WIDTH];
            s_axi_rdata     = m_axi_rdata[m*DATA_WIDTH +: DATA_WIDTH];
            s_axi_rresp     = m_axi_rresp[m*2 +: 2];
            s_axi_rlast     = m_axi_rlast[m];
            s_axi_rvalid    = m_axi_rvalid[m];
            m_axi_rready[m] = s_axi_rready;
          end
        end
      end
      ST_DERR: begin
        s_axi_rvalid = 1'b1;
        s_axi_rid    = derr_id_q;
        s_axi_rresp  = RRESP_DECERR;
        s_axi_rlast  = (cnt_q == derr_len_q);
      end
      default: ;
    endcase
  end

  // Failed-read command capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      derr_id_q  <= '0;
      derr_len_q <= '0;
    end else if (state_q == ST_IDLE && rc_valid && rc_decerr) begin
      derr_id_q  <= rc_id;
      derr_len_q <= rc_len;
    end
  end

  // Completion pulse one cycle after any last-beat handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_cpl_valid <= 1'b0;
      s_cpl_id    <= '0;
    end else begin
      s_cpl_valid <= last_hs;
      if (last_hs) begin
        s_cpl_id <= s_axi_rid;
      end
    end
  end

endmodule

// File: tb/tb_axi_sft_crossbar_rresp.sv
// tb/tb_axi_sft_crossbar_rresp.sv - self-checking bench for axi_sft_crossbar_rresp
module tb_axi_sft_crossbar_rresp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rc_valid, rc_decerr, rc_ready;
  logic [7:0]  rc_id, rc_len;
  logic [31:0] m_axi_rid;
  logic [127:0] m_axi_rdata;
  logic [7:0]  m_axi_rresp;
  logic [3:0]  m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic [7:0]  s_axi_rid;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rlast, s_axi_rvalid, s_axi_rready;
  logic [7:0]  s_cpl_id;
  logic        s_cpl_valid, tmr_mismatch;

  logic [3:0]  rv, rl;
  logic [31:0] dat;

  int n_tests = 0;
  int n_fail  = 0;

  // Master m returns RID 3+m, RRESP m, RDATA dat + m<<28.
  assign m_axi_rvalid = rv;
  assign m_axi_rlast  = rl;
  assign m_axi_rid    = {8'h06, 8'h05, 8'h04, 8'h03};
  assign m_axi_rresp  = {2'd3, 2'd2, 2'd1, 2'd0};
  assign m_axi_rdata  = {dat + 32'h3000_0000, dat + 32'h2000_0000, dat + 32'h1000_0000, dat};

  always #5 clk = ~clk;

  axi_sft_crossbar_rresp dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rc_valid    (rc_valid),
    .rc_decerr   (rc_decerr),
    .rc_id       (rc_id),
    .rc_len      (rc_len),
    .rc_ready    (rc_ready),
    .m_axi_rid   (m_axi_rid),
    .m_axi_rdata (m_axi_rdata),
    .m_axi_rresp (m_axi_rresp),
    .m_axi_rlast (m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready),
    .s_axi_rid   (s_axi_rid),
    .s_axi_rdata (s_axi_rdata),
    .s_axi_rresp (s_axi_rresp),
    .s_axi_rlast (s_axi_rlast),
    .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready),
    .s_cpl_id    (s_cpl_id),
    .s_cpl_valid (s_cpl_valid),
    .tmr_mismatch(tmr_mismatch)
  );

  typedef struct {
    logic        rcv, rcd;
    logic [7:0]  rcid, rclen;
    logic [3:0]  rv, rl;
    logic        rr;
    logic [31:0] dat;
    logic        e_rcr;
    logic [3:0]  e_mrr;
    logic        e_sv;
    logic [7:0]  e_sid;
    logic [31:0] e_sd;
    logic [1:0]  e_sr;
    logic        e_sl, e_cv;
    logic [7:0]  e_cid;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rcv, input logic rcd, input logic [7:0] rcid, input logic [7:0] rclen,
                     input logic [3:0] v, input logic [3:0] l, input logic r, input logic [31:0] d,
                     input logic e_rcr, input logic [3:0] e_mrr, input logic e_sv, input logic [7:0] e_sid,
                     input logic [31:0] e_sd, input logic [1:0] e_sr, input logic e_sl,
                     input logic e_cv, input logic [7:0] e_cid);
    vec_t x;
    x = '{rcv, rcd, rcid, rclen, v, l, r, d, e_rcr, e_mrr, e_sv, e_sid, e_sd, e_sr, e_sl, e_cv, e_cid};
    tbl.push_back(x);
  endtask

  task automatic chk(input bit ok, input string name, input string detail);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  function automatic string got_str();
    return $sformatf("got rcr=%b mrr=%b sv=%b rid=%h rdata=%h rresp=%0d rlast=%b cv=%b cid=%h tmr=%b",
                     rc_ready, m_axi_rready, s_axi_rvalid, s_axi_rid, s_axi_rdata, s_axi_rresp,
                     s_axi_rlast, s_cpl_valid, s_cpl_id, tmr_mismatch);
  endfunction

  task automatic check_row(input int i, input vec_t v);
    bit ok;
    ok = (rc_ready === v.e_rcr) && (m_axi_rready === v.e_mrr) && (s_axi_rvalid === v.e_sv) &&
         (s_cpl_valid === v.e_cv) && (tmr_mismatch === 1'b0);
    if (v.e_sv) ok = ok && (s_axi_rid === v.e_sid) && (s_axi_rdata === v.e_sd) &&
                     (s_axi_rresp === v.e_sr) && (s_axi_rlast === v.e_sl);
    if (v.e_cv) ok = ok && (s_cpl_id === v.e_cid);
    chk(ok, $sformatf("row%0d", i),
        $sformatf("%s; want rcr=%b mrr=%b sv=%b rid=%h rdata=%h rresp=%0d rlast=%b cv=%b cid=%h tmr=0",
                  got_str(), v.e_rcr, v.e_mrr, v.e_sv, v.e_sid, v.e_sd, v.e_sr, v.e_sl, v.e_cv, v.e_cid));
  endtask

  // Exact check of the slave-port fields (used for the DECERR stream and reset).
  task automatic check_out(input string name, input logic e_sv, input logic [7:0] e_sid,
                           input logic [31:0] e_sd, input logic [1:0] e_sr, input logic e_sl,
                           input logic [3:0] e_mrr, input logic e_cv);
    bit ok;
    ok = (s_axi_rvalid === e_sv) && (s_axi_rid === e_sid) && (s_axi_rdata === e_sd) &&
         (s_axi_rresp === e_sr) && (s_axi_rlast === e_sl) && (m_axi_rready === e_mrr) &&
         (s_cpl_valid === e_cv);
    chk(ok, name, $sformatf("%s; want sv=%b rid=%h rdata=%h rresp=%0d rlast=%b mrr=%b cv=%b",
                            got_str(), e_sv, e_sid, e_sd, e_sr, e_sl, e_mrr, e_cv));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    int beats;
    int cyc;
    rst_n = 1'b0; rc_valid = 1'b0; rc_decerr = 1'b0; rc_id = '0; rc_len = '0;
    rv = '0; rl = '0; dat = '0; s_axi_rready = 1'b0;

    //   rcv rcd id     len    rv       rl       rr  dat              rcr mrr     sv sid    sdata            sr sl cv cid
    // Master 2, 4-beat burst, id 0x05
    add(0, 0, 8'h00, 8'h00, 4'b0100, 4'b0000, 1, 32'h0,        0, 4'b0000, 0, 8'h00, 32'h0,        0, 0, 0, 8'h00);
    add(0, 0, 8'h00, 8'h00, 4'b0100, 4'b0000, 1, 32'h1,        0, 4'b0100, 1, 8'h05, 32'h2000_0001, 2, 0, 0, 8'h00);
    add(0, 0, 8'h00, 8'h00, 4'b0100, 4'b0000, 1, 32'h2,        0, 4'b0100, 1, 8'h05, 32'h2000_0002, 2, 0, 0, 8'h00);
    add(0, 0, 8'h00, 8'h00, 4'b0100, 4'b0000, 1, 32'h3,        0, 4'b0100, 1, 8'h05, 32'h2000_0003, 2, 0, 0, 8'h00);
    add(0, 0, 8'h00, 8'h00, 4'b0100, 4'b0100, 1, 32'h4,        0, 4'b0100, 1, 8'h05, 32'h2000_0004, 2, 1, 0, 8'h00);
    add(0, 0, 8'h00, 8'h00, 4'b0000, 4'b0000, 1, 32'h0,        0, 4'b0000, 0, 8'h00, 32'h0,        0, 0, 1, 8'h05);
    // rr_ptr now 3: masters 0 and 3 request, 3 wins
    add(0, 0, 8'h00, 8'h00, 4'b1001, 4'b0000, 1, 32'h0,        0, 4'b0000, 0, 8'h00, 32'h0,        0, 0, 0, 8'h00);
    add(0, 0, 8'h00, 8'h00, 4'b1001, 4'b1000, 1, 32'h5,        0, 4'b1000, 1, 8'h06, 32'h3000_0005, 3, 1, 0, 8'h00);
    // Masters 0,1,3 continuously, 2-beat bursts from rr_ptr 0 -> 0,1,3,0
    add(0, 0, 8'h00, 8'h00, 4'b1011, 4'b0000, 1, 32'h0,        0, 4'b0000, 0, 8'h00, 32'h0,        0, 0, 1, 8'h06);
    add(0, 0, 8'h00, 8'h00, 4'b1011, 4'b0000, 1, 32'h10,       0, 4'b0001, 1, 8'h03, 32'h0000_0010, 0, 0, 0, 8'h00);
    add(0, 0, 8'h00, 8'h00, 4'b1011, 4'b1011, 1, 32'h11,       0, 4'b0001, 1, 8'h03, 32'h0000_0011, 0, 1, 0, 8'h00);
    add(0, 0, 8'h00, 8'h00, 4'b1011, 4'b0000, 1, 32'h0,        0, 4'b0000, 0, 8'h00, 32'h0,        0, 0, 1, 8'h03);
    add(0, 0, 8'h00, 8'h00, 4'b1011, 4'b0000, 1, 32'h20,       0, 4'b0010, 1, 8'h04, 32'h1000_0020, 1, 0, 0, 8'h00);
    add(0, 0, 8'h00, 8'h00, 4'b1011, 4'b1011, 1, 32'h21,       0, 4'b0010, 1, 8'h04, 32'h1000_0021, 1, 1, 0, 8'h00);
    add(0, 0, 8'h00, 8'h00, 4'b1011, 4'b0000, 1, 32'h0,        0, 4'b0000, 0, 8'h00, 32'h0,        0, 0, 1, 8'h04);
    add(0, 0, 8'h00, 8'h00, 4'b1011, 4'b0000, 1, 32'h30,       0, 4'b1000, 1, 8'h06, 32'h3000_0030, 3, 0, 0, 8'h00);
    add(0, 0, 8'h00, 8'h00, 4'b1011, 4'b1011, 1, 32'h31,       0, 4'b1000, 1, 8'h06, 32'h3000_0031, 3, 1, 0, 8'h00);
    add(0, 0, 8'h00, 8'h00, 4'b1011, 4'b0000, 1, 32'h0,        0, 4'b0000, 0, 8'h00, 32'h0,        0, 0, 1, 8'h06);
    add(0, 0, 8'h00, 8'h00, 4'b1011, 4'b0000, 1, 32'h40,       0, 4'b0001, 1, 8'h03, 32'h0000_0040, 0, 0, 0, 8'h00);
    // stall: outputs held, rready to master dropped
    add(0, 0, 8'h00, 8'h00, 4'b1011, 4'b0000, 0, 32'h40,       0, 4'b0000, 1, 8'h03, 32'h0000_0040, 0, 0, 0, 8'h00);
    add(0, 0, 8'h00, 8'h00, 4'b1011, 4'b1011, 1, 32'h41,       0, 4'b0001, 1, 8'h03, 32'h0000_0041, 0, 1, 0, 8'h00);
    add(0, 0, 8'h00, 8'h00, 4'b0000, 4'b0000, 1, 32'h0,        0, 4'b0000, 0, 8'h00, 32'h0,        0, 0, 1, 8'h03);
    // DECERR id 7 len 2 together with master 0 rvalid: DERR first
    add(1, 1, 8'h07, 8'h02, 4'b0001, 4'b0000, 1, 32'h0,        1, 4'b0000, 0, 8'h00, 32'h0,        0, 0, 0, 8'h00);
    add(0, 0, 8'h00, 8'h00, 4'b0001, 4'b0000, 1, 32'h0,        0, 4'b0000, 1, 8'h07, 32'h0,        3, 0, 0, 8'h00);
    add(0, 0, 8'h00, 8'h00, 4'b0001, 4'b0000, 1, 32'h0,        0, 4'b0000, 1, 8'h07, 32'h0,        3, 0, 0, 8'h00);
    add(0, 0, 8'h00, 8'h00, 4'b0001, 4'b0000, 1, 32'h0,        0, 4'b0000, 1, 8'h07, 32'h0,        3, 1, 0, 8'h00);
    add(0, 0, 8'h00, 8'h00, 4'b0001, 4'b0000, 1, 32'h0,        0, 4'b0000, 0, 8'h00, 32'h0,        0, 0, 1, 8'h07);
    add(0, 0, 8'h00, 8'h00, 4'b0001, 4'b0001, 1, 32'h50,       0, 4'b0001, 1, 8'h03, 32'h0000_0050, 0, 1, 0, 8'h00);
    add(0, 0, 8'h00, 8'h00, 4'b0000, 4'b0000, 1, 32'h0,        0, 4'b0000, 0, 8'h00, 32'h0,        0, 0, 1, 8'h03);
    // Non-decerr command: acked, dropped, and still blocks arbitration that cycle
    add(1, 0, 8'h09, 8'h03, 4'b0010, 4'b0000, 1, 32'h0,        1, 4'b0000, 0, 8'h00, 32'h0,        0, 0, 0, 8'h00);
    add(0, 0, 8'h00, 8'h00, 4'b0010, 4'b0000, 1, 32'h0,        0, 4'b0000, 0, 8'h00, 32'h0,        0, 0, 0, 8'h00);
    add(0, 0, 8'h00, 8'h00, 4'b0010, 4'b0010, 1, 32'h60,       0, 4'b0010, 1, 8'h04, 32'h1000_0060, 1, 1, 0, 8'h00);
    add(0, 0, 8'h00, 8'h00, 4'b0000, 4'b0000, 1, 32'h0,        0, 4'b0000, 0, 8'h00, 32'h0,        0, 0, 1, 8'h04);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_out("reset_outputs", 0, 8'h00, 32'h0, 2'd0, 0, 4'b0000, 0);
    chk(rc_ready === 1'b0 && s_cpl_id === 8'h00 && tmr_mismatch === 1'b0, "reset_misc",
        $sformatf("%s; want rcr=0 cid=00 tmr=0", got_str()));
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      rc_valid = tbl[i].rcv; rc_decerr = tbl[i].rcd; rc_id = tbl[i].rcid; rc_len = tbl[i].rclen;
      rv = tbl[i].rv; rl = tbl[i].rl; s_axi_rready = tbl[i].rr; dat = tbl[i].dat;
      #1;
      check_row(i, tbl[i]);
    end

    // DECERR len 255 with rready toggling 1-0-1: exactly 256 beats, one completion
    @(negedge clk);
    rc_valid = 1'b1; rc_decerr = 1'b1; rc_id = 8'h2A; rc_len = 8'hFF; rv = '0; rl = '0; s_axi_rready = 1'b1;
    #1;
    chk(rc_ready === 1'b1, "derr256_accept", $sformatf("got rcr=%b want 1", rc_ready));
    @(negedge clk);
    rc_valid = 1'b0; rc_decerr = 1'b0;
    beats = 0;
    cyc = 0;
    while (beats < 256 && cyc < 1000) begin
      s_axi_rready = (cyc % 2 == 0);
      #1;
      check_out($sformatf("derr256_beat%0d", beats), 1, 8'h2A, 32'h0, 2'd3, (beats == 255), 4'b0000, 0);
      if (s_axi_rready) beats++;
      cyc++;
      @(negedge clk);
    end
    chk(beats == 256, "derr256_budget", $sformatf("got %0d beats in %0d cycles, want 256", beats, cyc));
    s_axi_rready = 1'b1;
    #1;
    check_out("derr256_cpl", 0, 8'h00, 32'h0, 2'd0, 0, 4'b0000, 1);
    chk(s_cpl_id === 8'h2A, "derr256_cpl_id", $sformatf("got %h want 2a", s_cpl_id));
    @(negedge clk);
    #1;
    check_out("derr256_single_cpl", 0, 8'h00, 32'h0, 2'd0, 0, 4'b0000, 0);

    // Reset mid-burst in FWD (rr_ptr is 2 before the reset)
    @(negedge clk);
    rv = 4'b0100; rl = '0; dat = 32'h70;
    @(negedge clk);
    #1;
    check_out("rst_pre_fwd", 1, 8'h05, 32'h2000_0070, 2'd2, 0, 4'b0100, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_out("rst_async_outputs", 0, 8'h00, 32'h0, 2'd0, 0, 4'b0000, 0);
    chk(s_cpl_id === 8'h00 && rc_ready === 1'b0, "rst_async_cpl_id", $sformatf("%s; want cid=00 rcr=0", got_str()));
    @(negedge clk);
    rst_n = 1'b1; rv = 4'b0101; rl = '0; dat = 32'h71;
    #1;
    check_out("rst_release_idle", 0, 8'h00, 32'h0, 2'd0, 0, 4'b0000, 0);
    @(negedge clk);
    rl = 4'b0101;
    #1;
    check_out("rst_rrptr_zero", 1, 8'h03, 32'h0000_0071, 2'd0, 1, 4'b0001, 0);
    @(negedge clk);
    rv = '0; rl = '0;
    #1;
    chk(s_cpl_valid === 1'b1 && s_cpl_id === 8'h03, "rst_next_cpl",
        $sformatf("got cv=%b cid=%h want cv=1 cid=03", s_cpl_valid, s_cpl_id));

`ifdef AXI_SFT_RRESP_TMR_EN
    // Upset one copy during FWD: voted outputs unchanged, one-cycle mismatch
    @(negedge clk);
    rv = 4'b0100; rl = '0; dat = 32'h80;
    @(negedge clk);
    force dut.tmr_q1 = '1;
    #1;
    chk(tmr_mismatch === 1'b1, "tmr_mismatch_set", $sformatf("got %b want 1", tmr_mismatch));
    check_out("tmr_voted_fwd", 1, 8'h05, 32'h2000_0080, 2'd2, 0, 4'b0100, 0);
    release dut.tmr_q1;
    @(negedge clk);
    rl = 4'b0100;
    #1;
    chk(tmr_mismatch === 1'b0, "tmr_scrubbed", $sformatf("got %b want 0", tmr_mismatch));
    check_out("tmr_fwd_after", 1, 8'h05, 32'h2000_0080, 2'd2, 1, 4'b0100, 0);
    @(negedge clk);
    rv = '0; rl = '0;
    #1;
    chk(s_cpl_valid === 1'b1 && s_cpl_id === 8'h05, "tmr_cpl",
        $sformatf("got cv=%b cid=%h want cv=1 cid=05", s_cpl_valid, s_cpl_id));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
